// File: rtl/pipe_adder_n_if.sv
// Operand/result handshake bundle for pipe_adder_n.
// ovf exists only when ADDER_OVF_EN is defined.
interface pipe_adder_n_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef ADDER_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout
`ifdef ADDER_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout
`ifdef ADDER_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/pipe_adder_n.sv
// Pipelined WIDTH-bit add/subtract, carry chain split into STAGES registered chunks.
// Optional signed-overflow output when ADDER_OVF_EN is defined.
module pipe_adder_n #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input logic           clk,
  input logic           rst_n,
  pipe_adder_n_if.slave bus
);
  localparam int unsigned DEPTH = (STAGES == 0) ? 1 : STAGES;
  localparam int unsigned CW    = WIDTH / DEPTH;
  localparam int unsigned LAST  = DEPTH - 1;

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % DEPTH) != 0) begin : g_bad_cfg
    $error("pipe_adder_n: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  // Subtract folds into an add of the inverted operand and inverted borrow.
  assign b_eff = bus.sub ? ~bus.b : bus.b;
  assign c_eff = bus.sub ? ~bus.cin : bus.cin;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] s_in;
    logic [WIDTH-1:0] s_nxt;
    logic             c_in;
    logic             v_in;
    logic [CW:0]      chunk;
    logic             v_q;
    logic             c_q;
    logic [WIDTH-1:0] s_q;

    if (k == 0) begin : g_head
      assign a_in = bus.a;
      assign b_in = b_eff;
      assign s_in = '0;
      assign c_in = c_eff;
      assign v_in = bus.in_valid;
    end else begin : g_body
      assign a_in = g_stage[k-1].g_fwd.a_q;
      assign b_in = g_stage[k-1].g_fwd.b_q;
      assign s_in = g_stage[k-1].s_q;
      assign c_in = g_stage[k-1].c_q;
      assign v_in = g_stage[k-1].v_q;
    end

    assign chunk = (CW+1)'(CW'(a_in >> (k * CW))) + (CW+1)'(CW'(b_in >> (k * CW)))
                 + (CW+1)'(c_in);

    // Splice this stage's chunk into the partial sum from upstream.
    always_comb begin
      s_nxt                = s_in;
      s_nxt[k*CW +: CW]    = chunk[CW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (adv) begin
        v_q <= v_in;
        c_q <= chunk[CW];
        s_q <= s_nxt;
      end
    end

    // Operands still needed by downstream chunks.
    if (k != LAST) begin : g_fwd
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_in;
          b_q <= b_in;
        end
      end
    end
  end

  // Global stall: every stage holds while a result waits to be taken.
  assign adv           = bus.out_ready || !g_stage[LAST].v_q;
  assign bus.in_ready  = adv;
  assign bus.out_valid = g_stage[LAST].v_q;
  assign bus.sum       = g_stage[LAST].s_q;
  assign bus.cout      = g_stage[LAST].c_q;

`ifdef ADDER_OVF_EN
  logic ovf_q;
  logic ovf_nxt;

  assign ovf_nxt = (g_stage[LAST].a_in[WIDTH-1] == g_stage[LAST].b_in[WIDTH-1])
                && (g_stage[LAST].s_nxt[WIDTH-1] != g_stage[LAST].a_in[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (adv) begin
      ovf_q <= ovf_nxt;
    end
  end

  assign bus.ovf = ovf_q;
`endif
endmodule

// File: tb/tb_pipe_adder_n.sv
// Scoreboard bench for pipe_adder_n: 8-bit/2-stage main instance plus 2-bit
// instances (1 and 2 stages) swept exhaustively.
module tb_pipe_adder_n;
  localparam int unsigned W  = 8;
  localparam int unsigned ST = 2;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           acc_cyc;
    bit           chk_lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipe_adder_n_if #(.WIDTH(W)) bus ();
  pipe_adder_n_if #(.WIDTH(2)) bus1 ();
  pipe_adder_n_if #(.WIDTH(2)) bus2 ();

  pipe_adder_n #(.WIDTH(W), .STAGES(ST)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  pipe_adder_n #(.WIDTH(2), .STAGES(1))  dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  pipe_adder_n #(.WIDTH(2), .STAGES(2))  dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  exp_t       sbq[$];
  logic [2:0] q1[$];
  logic [2:0] q2[$];
  bit         rnd_ready  = 0;
  bit         ready_force = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    exp_t e;
    int ua, ub, sa, sb, ci, r, sr;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    ci = cin ? 1 : 0;
    if (sub) begin
      r  = ua - ub - ci;
      sr = sa - sb - ci;
      e.cout = (r >= 0);
    end else begin
      r  = ua + ub + ci;
      sr = sa + sb + ci;
      e.cout = (r > 255);
    end
    e.sum     = W'(r);
    e.ovf     = (sr < -128) || (sr > 127);
    e.acc_cyc = 0;
    e.chk_lat = 0;
    return e;
  endfunction

  // Downstream ready: forced value or random, changed away from both edges.
  always @(posedge clk) begin
    #2;
    bus.out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : ready_force;
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic sub, input bit lat, input bit rdy_chk);
    exp_t x;
    int   n;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.cin = cin;
    bus.sub = sub;
    #1;
    if (rdy_chk) chk("in_ready_b2b", 32'(bus.in_ready), 32'd1);
    n = 0;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", n);
      bus.in_valid = 1'b0;
    end else begin
      x = model(a, b, cin, sub);
      x.acc_cyc = cyc;
      x.chk_lat = lat;
      sbq.push_back(x);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
  endtask

  // Monitor for the main instance: stall stability and in-order results.
  exp_t       m_e;
  bit         stall_prev = 0;
  logic [8:0] prev_out;
  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        chk("stall_hold_valid", 32'(bus.out_valid), 32'd1);
        chk("stall_hold_result", 32'({bus.cout, bus.sum}), 32'(prev_out));
      end
      if (bus.out_valid && !bus.out_ready) chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      if (bus.out_valid && bus.out_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got sum=0x%0h with nothing outstanding", bus.sum);
        end else begin
          m_e = sbq.pop_front();
          chk("sum", 32'(bus.sum), 32'(m_e.sum));
          chk("cout", 32'(bus.cout), 32'(m_e.cout));
`ifdef ADDER_OVF_EN
          chk("ovf", 32'(bus.ovf), 32'(m_e.ovf));
`endif
          if (m_e.chk_lat) chk("latency", 32'(cyc - m_e.acc_cyc), 32'(ST));
        end
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      prev_out   = {bus.cout, bus.sum};
    end
  end

  // Monitors for the 2-bit instances.
  always @(negedge clk) begin
    #1;
    if (rst_n && bus1.out_valid) begin
      if (q1.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL w2s1_unexpected: got 0x%0h", {bus1.cout, bus1.sum});
      end else begin
        chk("w2s1_sum", 32'({bus1.cout, bus1.sum}), 32'(q1.pop_front()));
      end
    end
    if (rst_n && bus2.out_valid) begin
      if (q2.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL w2s2_unexpected: got 0x%0h", {bus2.cout, bus2.sum});
      end else begin
        chk("w2s2_sum", 32'({bus2.cout, bus2.sum}), 32'(q2.pop_front()));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0;  bus.a = '0;  bus.b = '0;  bus.cin = 1'b0;  bus.sub = 1'b0;
    bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0; bus1.sub = 1'b0;
    bus1.out_ready = 1'b1;
    bus2.in_valid = 1'b0; bus2.a = '0; bus2.b = '0; bus2.cin = 1'b0; bus2.sub = 1'b0;
    bus2.out_ready = 1'b1;

    #13;
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_sum", 32'(bus.sum), 32'd0);
    chk("reset_cout", 32'(bus.cout), 32'd0);
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
`ifdef ADDER_OVF_EN
    chk("reset_ovf", 32'(bus.ovf), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    ready_force = 1'b1;
    idle(2);

    // Directed corner cases.
    issue(8'hFF, 8'h01, 1'b0, 1'b0, 1, 0);
    issue(8'h05, 8'h07, 1'b0, 1'b1, 1, 0);
    issue(8'h7F, 8'h01, 1'b0, 1'b0, 1, 0);
    issue(8'h80, 8'h01, 1'b1, 1'b1, 1, 0);
    idle(4);

    // Back-to-back at full throughput.
    for (int i = 1; i <= 4; i++) issue(W'(i), W'(i), 1'b0, 1'b0, 1, 1);
    idle(4);

    // Backpressure with a result pending and a new op waiting.
    issue(8'h10, 8'h20, 1'b0, 1'b0, 0, 0);
    issue(8'h30, 8'h40, 1'b1, 1'b0, 0, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    ready_force = 1'b0;
    fork
      begin
        repeat (4) @(negedge clk);
        ready_force = 1'b1;
      end
    join_none
    issue(8'h55, 8'h66, 1'b0, 1'b1, 0, 0);
    idle(6);

    // Random traffic with random downstream stalls.
    rnd_ready = 1;
    for (int i = 0; i < 200; i++) begin
      issue(W'($urandom), W'($urandom), 1'(($urandom >> 4) & 1), 1'(($urandom >> 7) & 1), 0, 0);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(1);
    rnd_ready = 0;
    ready_force = 1'b1;
    for (int i = 0; i < 100 && sbq.size() != 0; i++) @(negedge clk);
    chk("drain_empty", 32'(sbq.size()), 32'd0);

    // Asynchronous reset with two operations in flight.
    issue(8'h11, 8'h22, 1'b0, 1'b0, 0, 0);
    issue(8'h33, 8'h44, 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("async_reset_sum", 32'(bus.sum), 32'd0);
    sbq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      #1;
      chk("post_reset_idle", 32'(bus.out_valid), 32'd0);
    end

    // Exhaustive 2-bit sweep, both pipeline depths.
    for (int i = 0; i < 16; i++) begin
      logic [3:0] v;
      v = 4'(i);
      @(negedge clk);
      bus1.in_valid = 1'b1; bus1.a = v[3:2]; bus1.b = v[1:0];
      bus2.in_valid = 1'b1; bus2.a = v[3:2]; bus2.b = v[1:0];
      q1.push_back(3'(v[3:2]) + 3'(v[1:0]));
      q2.push_back(3'(v[3:2]) + 3'(v[1:0]));
      #1;
      chk("w2s1_in_ready", 32'(bus1.in_ready), 32'd1);
      chk("w2s2_in_ready", 32'(bus2.in_ready), 32'd1);
    end
    @(negedge clk);
    bus1.in_valid = 1'b0;
    bus2.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("w2s1_drain", 32'(q1.size()), 32'd0);
    chk("w2s2_drain", 32'(q2.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
